// File: rtl/rs232_pkg.sv
// Shared types and constants for the host-side RS232 receiver.
// Sample timing shifts by one cycle when RS232_HOST_RECV_MAJORITY_EN is defined.
package rs232_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

  localparam int unsigned NUM_SAMPLES = 10;
  localparam real         MIN_UNIT    = 8.0;

`ifdef RS232_HOST_RECV_MAJORITY_EN
  localparam int unsigned SAMPLE_DELAY = 1;
`else
  localparam int unsigned SAMPLE_DELAY = 0;
`endif

  // Cycle offset of the centre of bit k, measured from the first low cycle.
  function automatic int unsigned sample_point(input real unit, input int unsigned k);
    return unsigned'(int'(unit * (real'(k) + 0.5)));
  endfunction

endpackage

// File: rtl/rs232_rx_fifo.sv
// First-word-fall-through byte FIFO; a pop in the same cycle frees room for a push
// into a full buffer.
module rs232_rx_fifo
  import rs232_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] free_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $fatal(1, "rs232_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the head is masked to zero while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign free_o = CW'(DEPTH) - count_q;

endmodule

// File: rtl/rs232_host_recv.sv
// Host-side 8N1 receiver: synchronizer, frame FSM, FWFT byte buffer and RTS flow control.
// Define RS232_HOST_RECV_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module rs232_host_recv
  import rs232_pkg::*;
#(
  parameter real         CLOCK_FREQ = 133000000.0,
  parameter real         BAUD_RATE  = 115200.0,
  parameter int unsigned DEPTH      = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rxd_pin,
  output logic       rtsn_pin,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam real         UNIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned P9   = sample_point(UNIT, NUM_SAMPLES - 1);
  localparam int unsigned TW   = $clog2(P9 + 2);
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  if (UNIT < MIN_UNIT) begin : g_unit_check
    $fatal(1, "rs232_host_recv: fewer than 8 clocks per bit");
  end

  // Decision cycle of each of the ten samples, relative to the start edge.
  logic [TW-1:0] pt [NUM_SAMPLES];
  for (genvar gi = 0; gi < NUM_SAMPLES; gi++) begin : g_pt
    localparam int unsigned PK = sample_point(UNIT, gi) + SAMPLE_DELAY;
    assign pt[gi] = TW'(PK);
  end

  logic [1:0]    sync_q;
  logic          rxd;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          frame_err_q, frame_err_d;
  logic          rtsn_q;
  logic [TW-1:0] target;
  logic          sample_hit;
  logic          sample_bit;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_free;
  logic          pop;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd_pin};
    end
  end
  assign rxd = sync_q[1];

`ifdef RS232_HOST_RECV_MAJORITY_EN
  logic hist1_q;
  logic hist2_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= rxd;
      hist2_q <= hist1_q;
    end
  end

  // rxd is the Pk+1 sample, hist1 Pk, hist2 Pk-1.
  assign sample_bit = (rxd & hist1_q) | (rxd & hist2_q) | (hist1_q & hist2_q);
`else
  assign sample_bit = rxd;
`endif

  always_comb begin
    target = pt[0];
    unique case (state_q)
      S_DATA:  target = pt[4'(bit_idx_q) + 4'd1];
      S_STOP:  target = pt[NUM_SAMPLES - 1];
      default: target = pt[0];
    endcase
  end
  assign sample_hit = (timer_q == target);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rxd) begin
          state_d = S_START;
          timer_d = TW'(1);
        end
      end
      S_START: begin
        timer_d = timer_q + TW'(1);
        if (sample_hit) begin
          if (sample_bit) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        timer_d = timer_q + TW'(1);
        if (sample_hit) begin
          shift_d   = {sample_bit, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        timer_d = timer_q + TW'(1);
        if (sample_hit) begin
          timer_d = '0;
          if (sample_bit) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        timer_d = '0;
        if (rxd) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pop = valid & ready;

  // shift_q stays untouched until the next frame's first data sample, so it
  // still holds the finished byte during the push cycle.
  rs232_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i       (clock),
    .rstn_i      (resetn),
    .push_i      (push_q),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .head_o      (data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .free_o      (fifo_free)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rtsn_q <= 1'b1;
    end else begin
      rtsn_q <= (fifo_free < CW'(2));
    end
  end

  assign valid       = ~fifo_empty;
  assign rtsn_pin    = rtsn_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = push_q & fifo_full & ~pop;

endmodule

// File: tb/tb_rs232_host_recv.sv
// Directed bench for rs232_host_recv at 10 clocks per bit; timing expectations follow
// RS232_HOST_RECV_MAJORITY_EN when it is defined.
module tb_rs232_host_recv;

`ifdef RS232_HOST_RECV_MAJORITY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  // Cycles from the first low line cycle: stop sample at 97, push at 98, valid at 99.
  localparam int PUSH_CYC  = 98 + LAT;
  localparam int VALID_CYC = 99 + LAT;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rxd_pin;
  logic       rtsn_pin;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun_err;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc = 0;
  int start_cyc = 0;
  int pop_cyc = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] rx_q [$];

  rs232_host_recv #(
    .CLOCK_FREQ (1152000.0),
    .BAUD_RATE  (115200.0),
    .DEPTH      (4)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .rxd_pin     (rxd_pin),
    .rtsn_pin    (rtsn_pin),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (resetn) begin
      if (valid) valid_cycles++;
      if (valid && ready) begin
        rx_q.push_back(data);
        pop_cyc = cyc;
        $display("[TB] popped 0x%02h at cycle %0d", data, cyc);
      end
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic idle_after);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    @(posedge clock);
    #1;
    start_cyc = cyc;
    $display("[TB] send 0x%02h stop=%0b at cycle %0d", b, stop_bit, cyc);
    for (int i = 0; i < 10; i++) begin
      rxd_pin = fr[i];
      repeat (10) @(posedge clock);
      #1;
    end
    rxd_pin = idle_after;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    ready   = 1'b0;
    rxd_pin = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    tests_run++;
    if (rtsn_pin !== 1'b1) begin tests_failed++; $display("FAIL reset_rtsn: got %b want 1", rtsn_pin); end
    tests_run++;
    if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests_run++;
    if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", data); end
    tests_run++;
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    tests_run++;
    if (overrun_err !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", overrun_err); end
    resetn = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (rtsn_pin !== 1'b0) begin tests_failed++; $display("FAIL post_reset_rtsn: got %b want 0", rtsn_pin); end
  endtask

  task automatic test_single_byte();
    int vc0, fe0, ov0;
    ready = 1'b1;
    rx_q.delete();
    vc0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (rx_q.size() !== 1) begin tests_failed++; $display("FAIL single_count: got %0d want 1", rx_q.size()); end
    else begin
      tests_run++;
      if (rx_q[0] !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %h want a5", rx_q[0]); end
    end
    tests_run++;
    if (pop_cyc - start_cyc !== VALID_CYC) begin
      tests_failed++; $display("FAIL single_latency: got %0d want %0d", pop_cyc - start_cyc, VALID_CYC);
    end
    tests_run++;
    if (valid_cycles - vc0 !== 1) begin tests_failed++; $display("FAIL single_valid_width: got %0d want 1", valid_cycles - vc0); end
    tests_run++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) begin
      tests_failed++; $display("FAIL single_errors: got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_false_start();
    int fe0;
    ready = 1'b1;
    rx_q.delete();
    fe0 = fe_cnt;
    @(posedge clock);
    #1;
    rxd_pin = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rxd_pin = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    tests_run++;
    if (rx_q.size() !== 0 || valid !== 1'b0) begin
      tests_failed++; $display("FAIL false_start_data: got %0d pops valid=%b want 0 0", rx_q.size(), valid);
    end
    tests_run++;
    if (fe_cnt - fe0 !== 0) begin tests_failed++; $display("FAIL false_start_fe: got %0d want 0", fe_cnt - fe0); end
    send_frame(8'hC3, 1'b1, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'hC3) begin
      tests_failed++; $display("FAIL false_start_rearm: got %0d bytes first=%h want 1 c3", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
  endtask

  task automatic test_frame_break();
    int fe0;
    ready = 1'b1;
    rx_q.delete();
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (500) @(posedge clock);
    #1;
    tests_run++;
    if (fe_cnt - fe0 !== 1) begin tests_failed++; $display("FAIL break_fe_count: got %0d want 1", fe_cnt - fe0); end
    tests_run++;
    if (rx_q.size() !== 0) begin tests_failed++; $display("FAIL break_no_push: got %0d want 0", rx_q.size()); end
    rxd_pin = 1'b1;
    repeat (20) @(posedge clock);
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h3C) begin
      tests_failed++; $display("FAIL break_recover: got %0d bytes first=%h want 1 3c", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
    tests_run++;
    if (fe_cnt - fe0 !== 1) begin tests_failed++; $display("FAIL break_fe_after: got %0d want 1", fe_cnt - fe0); end
  endtask

  task automatic test_flow_overrun();
    int ov0;
    ready = 1'b0;
    rx_q.delete();
    ov0 = ov_cnt;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h02, 1'b1, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (rtsn_pin !== 1'b0) begin tests_failed++; $display("FAIL flow_rtsn_two: got %b want 0", rtsn_pin); end
    send_frame(8'h03, 1'b1, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (rtsn_pin !== 1'b1) begin tests_failed++; $display("FAIL flow_rtsn_three: got %b want 1", rtsn_pin); end
    send_frame(8'h04, 1'b1, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (ov_cnt - ov0 !== 0) begin tests_failed++; $display("FAIL flow_fourth_stored: got %0d overruns want 0", ov_cnt - ov0); end
    send_frame(8'h05, 1'b1, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (ov_cnt - ov0 !== 1) begin tests_failed++; $display("FAIL flow_overrun: got %0d overruns want 1", ov_cnt - ov0); end
    tests_run++;
    if (valid !== 1'b1 || data !== 8'h01) begin
      tests_failed++; $display("FAIL flow_head_hold: got valid=%b data=%h want 1 01", valid, data);
    end
    ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    tests_run++;
    if (rx_q.size() !== 4) begin tests_failed++; $display("FAIL flow_drain_count: got %0d want 4", rx_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (rx_q[i] !== 8'(i + 1)) begin
          tests_failed++; $display("FAIL flow_drain_order: entry %0d got %h want %h", i, rx_q[i], 8'(i + 1));
        end
      end
    end
    tests_run++;
    if (rtsn_pin !== 1'b0 || valid !== 1'b0) begin
      tests_failed++; $display("FAIL flow_drained: got rtsn=%b valid=%b want 0 0", rtsn_pin, valid);
    end
  endtask

  task automatic test_full_push_pop();
    int ov0;
    logic [7:0] exp_b [5];
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    ready = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1, 1'b1);
    ov0 = ov_cnt;
    fork
      send_frame(8'h14, 1'b1, 1'b1);
      begin
        @(posedge clock);
        repeat (PUSH_CYC) @(posedge clock);
        #1;
        ready = 1'b1;
        @(posedge clock);
        #1;
        ready = 1'b0;
      end
    join
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (ov_cnt - ov0 !== 0) begin tests_failed++; $display("FAIL pushpop_overrun: got %0d want 0", ov_cnt - ov0); end
    tests_run++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h10) begin
      tests_failed++; $display("FAIL pushpop_pulse_pop: got %0d bytes first=%h want 1 10", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
    ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    tests_run++;
    if (rx_q.size() !== 5) begin tests_failed++; $display("FAIL pushpop_drain_count: got %0d want 5", rx_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (rx_q[i] !== exp_b[i]) begin
          tests_failed++; $display("FAIL pushpop_drain_order: entry %0d got %h want %h", i, rx_q[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int fe0;
    ready = 1'b1;
    rx_q.delete();
    fe0 = fe_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b1);
      begin
        @(posedge clock);
        repeat (53) @(posedge clock);
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if (rtsn_pin !== 1'b1 || valid !== 1'b0 || data !== 8'h00 || frame_err !== 1'b0 || overrun_err !== 1'b0) begin
          tests_failed++;
          $display("FAIL midreset_outputs: got rtsn=%b valid=%b data=%h fe=%b ov=%b want 1 0 00 0 0",
                   rtsn_pin, valid, data, frame_err, overrun_err);
        end
        @(posedge clock);
        #1;
        resetn = 1'b1;
      end
    join
    repeat (20) @(posedge clock);
    #1;
    tests_run++;
    if (rx_q.size() !== 0 || fe_cnt - fe0 !== 0) begin
      tests_failed++; $display("FAIL midreset_no_partial: got %0d bytes fe=%0d want 0 0", rx_q.size(), fe_cnt - fe0);
    end
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h5A) begin
      tests_failed++; $display("FAIL midreset_next: got %0d bytes first=%h want 1 5a", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_false_start();
    test_frame_break();
    test_flow_overrun();
    test_full_push_pop();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
